// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
//   Bundles the control inputs and status outputs of the program counter /
//   fetch sequencer. The core control logic uses the master modport; the
//   sequencer uses the slave modport.
//
//   Control (master -> slave):
//     stall, miss, jmp/jmp_field, call/call_target, br_taken/br_field, ret,
//     irq/irq_vec, err_clr
//   Status (slave -> master):
//     fetch_addr, exec_addr, redirect, stack_depth, stack_full, stack_empty,
//     ovf, unf
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int ADDR_W      = 16,
  parameter int JMP_W       = 13,
  parameter int OFF_W       = 8,
  parameter int STACK_DEPTH = 16,
  parameter int VEC_W       = 3
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

  // control
  logic              stall;
  logic              miss;
  logic              jmp;
  logic [JMP_W-1:0]  jmp_field;
  logic              call;
  logic [ADDR_W-1:0] call_target;
  logic              br_taken;
  logic [OFF_W-1:0]  br_field;
  logic              ret;
  logic              irq;
  logic [VEC_W-1:0]  irq_vec;
  logic              err_clr;

  // status
  logic [ADDR_W-1:0]  fetch_addr;
  logic [ADDR_W-1:0]  exec_addr;
  logic               redirect;
  logic [DEPTH_W-1:0] stack_depth;
  logic               stack_full;
  logic               stack_empty;
  logic               ovf;
  logic               unf;

  modport master (
    output stall, miss, jmp, jmp_field, call, call_target, br_taken, br_field,
           ret, irq, irq_vec, err_clr,
    input  fetch_addr, exec_addr, redirect, stack_depth, stack_full,
           stack_empty, ovf, unf
  );

  modport slave (
    input  stall, miss, jmp, jmp_field, call, call_target, br_taken, br_field,
           ret, irq, irq_vec, err_clr,
    output fetch_addr, exec_addr, redirect, stack_depth, stack_full,
           stack_empty, ovf, unf
  );
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program counter and fetch sequencer for the RIPTIDE core.
//   - Issues the fetch address and carries instruction addresses down an
//     address pipeline of PIPE_STAGES stages to execute.
//   - Resolves redirects with fixed priority irq > call > br_taken > ret > jmp;
//     a losing redirect has no side effects at all.
//   - Replays the fetch address after a program-cache miss.
//   - Circular return stack: push on call/irq, pop on ret, with registered
//     depth/full/empty and sticky overflow/underflow flags.
//
//   Ports:
//     clk    : clock, all state updates on the rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : pc_sequencer_if.slave (control in, fetch/stack status out)
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int          ADDR_W      = 16,
  parameter int          JMP_W       = 13,
  parameter int          OFF_W       = 8,
  parameter int          STACK_DEPTH = 16,
  parameter int          PIPE_STAGES = 3,
  parameter int          VEC_W       = 3,
  parameter int unsigned VEC_BASE    = 0,
  parameter int unsigned RESET_ADDR  = 0
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);

  localparam int PTR_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0]  RST_PC   = ADDR_W'(RESET_ADDR);
  localparam logic [ADDR_W-1:0]  VEC_PC   = ADDR_W'(VEC_BASE);
  localparam logic [DEPTH_W-1:0] FULL_CNT = DEPTH_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_IRQ,
    SRC_CALL,
    SRC_BR,
    SRC_RET,
    SRC_JMP
  } redir_src_e;

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  logic [ADDR_W-1:0]  fetch_q;
  logic [ADDR_W-1:0]  prev_fetch_q;   // fetch address of the previous cycle
  logic               miss_q;         // miss was high last cycle (replay in progress)
  logic               redirect_q;
  logic [ADDR_W-1:0]  pipe_q [PIPE_STAGES];

  logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];
  logic [PTR_W-1:0]   top_ptr_q;      // next free slot; top of stack is one below
  logic [DEPTH_W-1:0] depth_q;
  logic               full_q;
  logic               empty_q;
  logic               ovf_q;
  logic               unf_q;

  // ------------------------------------------------------------------------
  // Redirect resolution
  // ------------------------------------------------------------------------
  logic [ADDR_W-1:0]  exec_pc;
  logic [VEC_W-1:0]   vec_idx;
  redir_src_e         src;
  logic [ADDR_W-1:0]  target;
  logic [ADDR_W-1:0]  push_data;
  logic               do_push;
  logic               do_pop;

  assign exec_pc = pipe_q[PIPE_STAGES-1];
  assign vec_idx = bus.irq_vec;

  always_comb begin
    if      (bus.irq)      src = SRC_IRQ;
    else if (bus.call)     src = SRC_CALL;
    else if (bus.br_taken) src = SRC_BR;
    else if (bus.ret)      src = SRC_RET;
    else if (bus.jmp)      src = SRC_JMP;
    else                   src = SRC_NONE;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    target    = exec_pc;
    push_data = exec_pc;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    unique case (src)
      SRC_IRQ: begin
        // The interrupted instruction is re-executed on return, so push its
        // own address rather than the next one.
        target    = VEC_PC + ADDR_W'(vec_idx);
        push_data = exec_pc;
        do_push   = 1'b1;
      end
      SRC_CALL: begin
        target    = bus.call_target;
        push_data = exec_pc + ADDR_W'(1);
        do_push   = 1'b1;
      end
      SRC_BR:  target = {exec_pc[ADDR_W-1:OFF_W], bus.br_field};
      SRC_RET: begin
        do_pop = 1'b1;
        target = empty_q ? RST_PC : stack_mem[top_ptr_q - PTR_W'(1)];
      end
      SRC_JMP: target = {exec_pc[ADDR_W-1:JMP_W], bus.jmp_field};
      default: ;
    endcase
  end

  // ------------------------------------------------------------------------
  // Return stack bookkeeping
  // ------------------------------------------------------------------------
  logic [PTR_W-1:0]   top_ptr_nxt;
  logic [DEPTH_W-1:0] depth_nxt;
  logic               ovf_nxt;
  logic               unf_nxt;

  always_comb begin
    top_ptr_nxt = top_ptr_q;
    depth_nxt   = depth_q;
    if (do_push) begin
      // When full, the write slot is the oldest entry: it is overwritten and
      // depth saturates.
      top_ptr_nxt = top_ptr_q + PTR_W'(1);
      if (!full_q) depth_nxt = depth_q + DEPTH_W'(1);
    end else if (do_pop && !empty_q) begin
      top_ptr_nxt = top_ptr_q - PTR_W'(1);
      depth_nxt   = depth_q - DEPTH_W'(1);
    end
    // A new error in the same cycle as err_clr keeps the flag set.
    ovf_nxt = (ovf_q & ~bus.err_clr) | (do_push & full_q);
    unf_nxt = (unf_q & ~bus.err_clr) | (do_pop & empty_q);
  end

  // NOTE: the stack storage has no reset; entries are only read below the
  // tracked depth, so their power-up contents never matter.
  always_ff @(posedge clk) begin
    if (do_push) stack_mem[top_ptr_q] <= push_data;
  end

  // ------------------------------------------------------------------------
  // PC, address pipeline and stack control registers
  // ------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q      <= RST_PC;
      prev_fetch_q <= RST_PC;
      miss_q       <= 1'b0;
      redirect_q   <= 1'b0;
      for (int k = 0; k < PIPE_STAGES; k++) pipe_q[k] <= RST_PC;
      top_ptr_q    <= '0;
      depth_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      redirect_q <= (src != SRC_NONE);

      if (src != SRC_NONE) begin
        // Flushed stages carry the target so an interrupt taken on a bubble
        // still pushes a meaningful return address. A miss reported next
        // cycle refers to the target, hence prev_fetch is loaded too.
        fetch_q      <= target;
        prev_fetch_q <= target;
        miss_q       <= 1'b0;
        for (int k = 0; k < PIPE_STAGES; k++) pipe_q[k] <= target;
      end else if (bus.miss) begin
        // First miss cycle rewinds to the missed address; later cycles hold.
        fetch_q      <= miss_q ? fetch_q : prev_fetch_q;
        prev_fetch_q <= fetch_q;
        miss_q       <= 1'b1;
      end else begin
        prev_fetch_q <= fetch_q;
        miss_q       <= 1'b0;
        if (!bus.stall) begin
          fetch_q   <= fetch_q + ADDR_W'(1);
          pipe_q[0] <= fetch_q;
          for (int k = 1; k < PIPE_STAGES; k++) pipe_q[k] <= pipe_q[k-1];
        end
      end

      top_ptr_q <= top_ptr_nxt;
      depth_q   <= depth_nxt;
      full_q    <= (depth_nxt == FULL_CNT);
      empty_q   <= (depth_nxt == '0);
      ovf_q     <= ovf_nxt;
      unf_q     <= unf_nxt;
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign bus.fetch_addr  = fetch_q;
  assign bus.exec_addr   = exec_pc;
  assign bus.redirect    = redirect_q;
  assign bus.stack_depth = depth_q;
  assign bus.stack_full  = full_q;
  assign bus.stack_empty = empty_q;
  assign bus.ovf         = ovf_q;
  assign bus.unf         = unf_q;

endmodule
